// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by unsigned shift-add and divides by restoring division. Either way
// it runs one step per cycle on a 2*XLEN accumulator. Signed ops work on
// magnitudes, and the sign is applied when the result is formed.
// Divide-by-zero and signed overflow skip the iteration phase.
//
// Handshake: start is taken only while busy=0 (IDLE). busy stays high from the
// cycle after accept through the done cycle. done is a one-cycle strobe that
// qualifies MDout/Zero. MDout/Zero hold until the next op completes or reset.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] MDop1,
    input  logic [XLEN-1:0] MDop2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MDout,
    output logic            Zero,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     b_reg;
    logic                neg;
    logic                special;
    logic [XLEN-1:0]     spec_res;

    // accept-time decode
    logic            s1, s2, div0, ovf, neg_in;
    logic [XLEN-1:0] mag1, mag2, spec_in;

    // iteration step and final result
    logic [XLEN:0]     mul_sum, div_p, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, res;

    assign dbg_state = state;

    // Decode operand signs, magnitudes and the special-case result at accept
    always_comb begin
        s1      = 1'b0;
        s2      = 1'b0;
        div0    = 1'b0;
        ovf     = 1'b0;
        neg_in  = 1'b0;
        spec_in = '0;
        // MDop1 is signed for MULH, MULHSU, DIV and REM
        s1 = MDop1[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                              (funct3 == 3'b100) | (funct3 == 3'b110));
        // MDop2 is signed for MULH, DIV and REM
        s2 = MDop2[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                              (funct3 == 3'b110));
        mag1 = s1 ? -MDop1 : MDop1;
        mag2 = s2 ? -MDop2 : MDop2;
        div0 = funct3[2] & (MDop2 == '0);
        ovf  = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
               (MDop1 == MIN_NEG) & (MDop2 == '1);
        // remainder follows the dividend's sign; everything else uses s1^s2
        neg_in = (funct3[2] & funct3[1]) ? s1 : (s1 ^ s2);
        if (funct3[1])
            spec_in = div0 ? MDop1 : '0;
        else
            spec_in = div0 ? '1 : MIN_NEG;
    end

    // One multiply step and one restoring-divide step on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_p    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_p - {1'b0, b_reg};
        div_ge   = (div_p >= {1'b0, b_reg});
        div_next = div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                          : {div_p[XLEN-1:0],    acc[XLEN-2:0], 1'b0};
    end

    // Apply the sign and pick the requested half or quotient/remainder
    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res  = '0;
        if (special)
            res = spec_res;
        else begin
            case (op)
                3'b000:                 res = prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         res = quo;
                default:                res = rem;
            endcase
        end
    end

    // Control FSM with registered busy/done/MDout/Zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            acc      <= '0;
            b_reg    <= '0;
            neg      <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            MDout    <= '0;
            Zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op       <= funct3;
                        acc      <= {{XLEN{1'b0}}, mag1};
                        b_reg    <= mag2;
                        neg      <= neg_in;
                        special  <= div0 | ovf;
                        spec_res <= spec_in;
                        cnt      <= CW'(XLEN - 1);
                        busy     <= 1'b1;
                        state    <= (div0 | ovf) ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    MDout <= res;
                    Zero  <= (res == '0);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a scoreboard queue of expected results is
// filled at issue and drained on each done pulse. Latency is checked as well.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT_FULL = XLEN + 1;  // posedges from accept edge to done
    localparam int LAT_BYP  = 1;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] MDop1, MDop2, MDout;
    logic            busy, done, Zero;
    logic [1:0]      dbg_state;

    logic [XLEN-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .MDop1(MDop1), .MDop2(MDop2), .busy(busy), .done(done),
        .MDout(MDout), .Zero(Zero), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // drive one request, push its expected result, scramble inputs afterwards
    task automatic issue(input string tag, input logic [2:0] f,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp);
        @(negedge clk);
        start = 1'b1; funct3 = f; MDop1 = a; MDop2 = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        MDop1 = $urandom; MDop2 = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        check({tag, " busy after accept"}, XLEN'(busy), 1);
    endtask

    // wait for done, optionally pulsing start at given cycles, then score
    task automatic wait_done(input string tag, input int exp_lat,
                             input int poke1, input int poke2);
        int lat;
        logic [XLEN-1:0] e;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 || lat >= 100) break;
            if (lat + 1 == poke1 || lat + 1 == poke2) begin
                start = 1'b1; funct3 = 3'b000; MDop1 = 1; MDop2 = 1;
            end
        end
        check({tag, " latency"}, XLEN'(lat), XLEN'(exp_lat));
        check({tag, " busy at done"}, XLEN'(busy), 1);
        if (exp_q.size() == 0) begin
            checks = checks + 1;
            $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " MDout"}, MDout, e);
            check({tag, " Zero"}, XLEN'(Zero), XLEN'(e == '0));
        end
        @(negedge clk);
        check({tag, " done one cycle"}, XLEN'(done), 0);
        check({tag, " busy released"}, XLEN'(busy), 0);
    endtask

    initial begin
        // reset with start asserted: reset must win
        rst = 1'b1; start = 1'b1; funct3 = 3'b000; MDop1 = 5; MDop2 = 6;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", XLEN'(busy), 0);
        check("reset done", XLEN'(done), 0);
        check("reset MDout", MDout, 0);
        check("reset Zero", XLEN'(Zero), 1);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("idle after reset", XLEN'(busy), 0);

        // basic multiply
        issue("mul 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_done("mul 7x-3", LAT_FULL, 0, 0);

        // high-half multiplies
        issue("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        wait_done("mulh", LAT_FULL, 0, 0);
        issue("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        wait_done("mulhu", LAT_FULL, 0, 0);
        issue("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
        wait_done("mulhsu", LAT_FULL, 0, 0);
        issue("mulhsu -1x3", 3'b010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);
        wait_done("mulhsu -1x3", LAT_FULL, 0, 0);

        // divide / remainder
        issue("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        wait_done("div -7/2", LAT_FULL, 0, 0);
        issue("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done("rem -7/2", LAT_FULL, 0, 0);
        issue("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
        wait_done("divu 100/7", LAT_FULL, 0, 0);
        issue("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2);
        wait_done("remu 100/7", LAT_FULL, 0, 0);
        issue("divu big", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        wait_done("divu big", LAT_FULL, 0, 0);
        issue("remu big", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
        wait_done("remu big", LAT_FULL, 0, 0);

        // special cases bypass the iteration phase
        issue("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_done("div 5/0", LAT_BYP, 0, 0);
        issue("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5);
        wait_done("remu 5/0", LAT_BYP, 0, 0);
        issue("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("div ovf", LAT_BYP, 0, 0);
        issue("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done("rem ovf", LAT_BYP, 0, 0);

        // start while busy is ignored
        issue("mul poked", 3'b000, 32'd1234, 32'd5678, 32'd7006652);
        wait_done("mul poked", LAT_FULL, 5, 20);
        @(negedge clk);
        check("no op after poke", XLEN'(busy), 0);

        // reset in the middle of a divide aborts it
        issue("div aborted", 3'b101, 32'd100, 32'd7, 32'd14);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort busy", XLEN'(busy), 0);
        check("abort done", XLEN'(done), 0);
        check("abort MDout", MDout, 0);
        check("abort Zero", XLEN'(Zero), 1);
        issue("mul 3x4", 3'b000, 32'd3, 32'd4, 32'd12);
        wait_done("mul 3x4", LAT_FULL, 0, 0);

        check("scoreboard drained", XLEN'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
